// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-side RAM + MMIO responder for the multicycle RV32I core
module data_mem_responder #(
    parameter int         DEPTH_WORDS = 1024,
    parameter logic [7:0] MMIO_PAGE   = 8'hC0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  MemSize,
    input  logic [31:0] A_Ram,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        data_valid,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [7:0]  leds
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          is_mmio;
    logic [23:0]   mmio_off;
    logic          size_ok;
    logic          aligned;
    logic          access_ok;
    logic          fault;
    logic          wr_ok;
    logic          rd_ok;
    logic          ram_we;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   mmio_rdata;
    logic [31:0]   cycle_cnt;

    // request stage: one pending read with the word and how to slice it
    logic          rd_pend;
    logic [31:0]   word_q;
    logic [2:0]    size_q;
    logic [1:0]    off_q;
    logic [7:0]    lane8;
    logic [15:0]   lane16;

    assign word_idx  = A_Ram[AW+1:2];
    assign is_mmio   = (A_Ram[31:24] == MMIO_PAGE);
    assign mmio_off  = A_Ram[23:0];
    assign access_ok = size_ok && aligned;
    // a simultaneous read+write still performs the write but counts as a fault
    assign fault     = (MemRead || MemWrite) && (!access_ok || (MemRead && MemWrite));
    assign wr_ok     = MemWrite && access_ok;
    assign rd_ok     = MemRead && !MemWrite && access_ok;
    assign ram_we    = wr_ok && !is_mmio;

    // size legality and alignment check
    always_comb begin
        size_ok = 1'b1;
        aligned = 1'b1;
        case (MemSize)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = !A_Ram[0];
            3'b010:         aligned = (A_Ram[1:0] == 2'b00);
            default:        size_ok = 1'b0;
        endcase
    end

    // store lane enables; data is replicated so each lane sees its own bytes
    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = WriteData;
        case (MemSize[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << A_Ram[1:0];
                wr_lanes = {4{WriteData[7:0]}};
            end
            2'b01: begin
                byte_en  = A_Ram[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{WriteData[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
    end

    // MMIO read mux, sampled at the request edge
    always_comb begin
        mmio_rdata = 32'd0;
        if (mmio_off == 24'h000000)
            mmio_rdata = {24'd0, leds};
        else if (mmio_off == 24'h000004)
            mmio_rdata = cycle_cnt;
    end

    // byte-lane RAM write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && byte_en[i])
                mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
    end

    // registered read: capture word, size and byte offset of a successful read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            word_q  <= 32'd0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            rd_pend <= rd_ok;
            if (rd_ok) begin
                word_q <= is_mmio ? mmio_rdata : mem[word_idx];
                size_q <= MemSize;
                off_q  <= A_Ram[1:0];
            end
        end
    end

    // MMIO registers, free-running counter and sticky fault capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            leds      <= 8'd0;
            err       <= 1'b0;
            err_addr  <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_ok && is_mmio && mmio_off == 24'h000000)
                leds <= WriteData[7:0];
            if (fault && !err) begin
                err      <= 1'b1;
                err_addr <= A_Ram;
            end
        end
    end

    assign lane8  = word_q[8*off_q +: 8];
    assign lane16 = off_q[1] ? word_q[31:16] : word_q[15:0];

    // lane extraction and sign/zero extension of the held word
    always_comb begin
        case (size_q)
            3'b000:  ReadData = {{24{lane8[7]}}, lane8};
            3'b100:  ReadData = {24'd0, lane8};
            3'b001:  ReadData = {{16{lane16[15]}}, lane16};
            3'b101:  ReadData = {16'd0, lane16};
            default: ReadData = word_q;
        endcase
    end

    assign data_valid = rd_pend;
endmodule
